// File: rtl/local_controller_prefetch_full.sv
// One node of a 4-node ring of sample-memory controllers: write, forward read and backward prefetch streams.
// Define LC_MAINT_WRITE_EN to enable the masked maintenance write port (WEBM/DM/BWEBM).
module local_controller_prefetch_full #(
  parameter int datawidth            = 16,
  parameter int address_vector_width = 8,
  parameter int sample_address_width = 8,
  parameter int packet_width         = 2*datawidth + address_vector_width
) (
  input  logic                              CLK,
  input  logic                              reset,
  input  logic [2*datawidth-1:0]            D,
  input  logic                              write_flag,
  input  logic                              input_write_boundary,
  output logic                              write_boundary_next,
  input  logic                              from_glob_controller_valid,
  input  logic [sample_address_width-1:0]   from_glob_controller_delay,
  input  logic [address_vector_width-1:0]   from_glob_dest_addr,
  input  logic                              input_boundary_flag,
  input  logic [address_vector_width-1:0]   prev_dest_address,
  output logic                              boundary_next,
  output logic [address_vector_width-1:0]   dest_address,
  output logic [packet_width-1:0]           packet_out,
  input  logic                              from_glob_prefetch_valid,
  input  logic [sample_address_width-1:0]   from_glob_prefetch_start,
  input  logic [sample_address_width-1:0]   from_glob_prefetch_stop,
  input  logic [address_vector_width-1:0]   from_glob_prefetch_dest,
  input  logic                              input_prefetch_boundary_flag,
  input  logic [sample_address_width-1:0]   prefetch_next_stop_address,
  input  logic [address_vector_width-1:0]   prefetch_next_dest_addr,
  output logic                              prefetch_boundary_prev,
  output logic [sample_address_width-1:0]   prefetch_stop_address,
  output logic [address_vector_width-1:0]   prefetch_dest_addr,
  output logic [packet_width-1:0]           prefetch_packet_out,
  input  logic                              scenario_update,
  input  logic                              WEBM,
  input  logic [2*datawidth-1:0]            DM,
  input  logic [2*datawidth-1:0]            BWEBM
);
  localparam int MW = 2*datawidth;
  localparam int AW = sample_address_width;
  localparam int VW = address_vector_width;
  localparam logic [AW-1:0] LAST = '1;

  logic [MW-1:0] r_mem [0:(1<<AW)-1];

  // write stream
  logic          r_wr_active, r_wbn;
  logic [AW-1:0] r_wr_ptr;
  logic          w_wr_start;
  logic [AW-1:0] w_wr_addr;
  assign w_wr_start = write_flag | input_write_boundary;
  assign w_wr_addr  = w_wr_start ? '0 : r_wr_ptr;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wr_active <= 1'b0;
      r_wr_ptr    <= '0;
      r_wbn       <= 1'b0;
    end else begin
      r_wbn <= 1'b0;
      if (w_wr_start) begin
        r_wr_ptr    <= AW'(1);
        r_wr_active <= 1'b1;
      end else if (r_wr_active) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_wr_ptr == LAST) begin
          r_wr_active <= 1'b0;
          r_wbn       <= 1'b1;
        end
      end
    end
  end

`ifdef LC_MAINT_WRITE_EN
  logic          w_maint_en;
  logic [MW-1:0] w_maint_word;
  assign w_maint_en   = !WEBM && !r_wr_active && !w_wr_start;
  assign w_maint_word = (r_mem[D[AW-1:0]] & BWEBM) | (DM & ~BWEBM);
`else
  logic          w_maint_en;
  logic [MW-1:0] w_maint_word;
  logic          w_unused_maint;
  assign w_maint_en     = 1'b0;
  assign w_maint_word   = '0;
  assign w_unused_maint = ^{WEBM, DM, BWEBM};
`endif

  // stream writes win over the maintenance port; memory is never reset
  always_ff @(posedge CLK) begin
    if (w_wr_start || r_wr_active) r_mem[w_wr_addr] <= D;
    else if (w_maint_en)           r_mem[D[AW-1:0]] <= w_maint_word;
  end

  // read stream (ascending, hands off forward)
  logic          r_rd_active, r_bnext;
  logic [AW-1:0] r_rd_addr;
  logic [VW-1:0] r_rd_dest;
  logic [packet_width-1:0] r_pkt;
  logic          w_rd_go;
  logic [AW-1:0] w_rd_addr;
  logic [VW-1:0] w_rd_dest;

  always_comb begin
    w_rd_go   = 1'b1;
    w_rd_addr = r_rd_addr;
    w_rd_dest = r_rd_dest;
    if (from_glob_controller_valid) begin
      w_rd_addr = from_glob_controller_delay;
      w_rd_dest = from_glob_dest_addr;
    end else if (input_boundary_flag) begin
      w_rd_addr = '0;
      w_rd_dest = prev_dest_address;
    end else begin
      w_rd_go = r_rd_active;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_rd_active <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_dest   <= '0;
      r_bnext     <= 1'b0;
      r_pkt       <= '0;
    end else if (scenario_update) begin
      r_rd_active <= 1'b0;
      r_rd_dest   <= '0;
      r_bnext     <= 1'b0;
      r_pkt       <= '0;
    end else begin
      r_bnext <= 1'b0;
      r_pkt   <= '0;
      if (w_rd_go) begin
        r_rd_dest   <= w_rd_dest;
        r_rd_addr   <= w_rd_addr + 1'b1;
        r_rd_active <= (w_rd_addr != LAST);
        r_bnext     <= (w_rd_addr == LAST);
        r_pkt       <= {w_rd_dest, r_mem[w_rd_addr]};
      end
    end
  end

  // prefetch stream (descending, hands off backward)
  logic          r_pf_active, r_bprev;
  logic [AW-1:0] r_pf_addr, r_pf_stop;
  logic [VW-1:0] r_pf_dest;
  logic [packet_width-1:0] r_pf_pkt;
  logic          w_pf_go;
  logic [AW-1:0] w_pf_addr, w_pf_stop;
  logic [VW-1:0] w_pf_dest;

  always_comb begin
    w_pf_go   = 1'b1;
    w_pf_addr = r_pf_addr;
    w_pf_stop = r_pf_stop;
    w_pf_dest = r_pf_dest;
    if (from_glob_prefetch_valid) begin
      w_pf_addr = from_glob_prefetch_start;
      w_pf_stop = from_glob_prefetch_stop;
      w_pf_dest = from_glob_prefetch_dest;
    end else if (input_prefetch_boundary_flag) begin
      w_pf_addr = LAST;
      w_pf_stop = prefetch_next_stop_address;
      w_pf_dest = prefetch_next_dest_addr;
    end else begin
      w_pf_go = r_pf_active;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_pf_active <= 1'b0;
      r_pf_addr   <= '0;
      r_pf_stop   <= '0;
      r_pf_dest   <= '0;
      r_bprev     <= 1'b0;
      r_pf_pkt    <= '0;
    end else if (scenario_update) begin
      r_pf_active <= 1'b0;
      r_pf_stop   <= '0;
      r_pf_dest   <= '0;
      r_bprev     <= 1'b0;
      r_pf_pkt    <= '0;
    end else begin
      r_bprev  <= 1'b0;
      r_pf_pkt <= '0;
      if (w_pf_go) begin
        r_pf_stop <= w_pf_stop;
        r_pf_dest <= w_pf_dest;
        r_pf_addr <= w_pf_addr - 1'b1;
        r_pf_pkt  <= {w_pf_dest, r_mem[w_pf_addr]};
        // the stop address takes precedence over the hand-off at address 0
        if (w_pf_addr == w_pf_stop) begin
          r_pf_active <= 1'b0;
        end else if (w_pf_addr == '0) begin
          r_pf_active <= 1'b0;
          r_bprev     <= 1'b1;
        end else begin
          r_pf_active <= 1'b1;
        end
      end
    end
  end

  assign write_boundary_next    = r_wbn;
  assign boundary_next          = r_bnext;
  assign dest_address           = r_rd_dest;
  assign packet_out             = r_pkt;
  assign prefetch_boundary_prev = r_bprev;
  assign prefetch_stop_address  = r_pf_stop;
  assign prefetch_dest_addr     = r_pf_dest;
  assign prefetch_packet_out    = r_pf_pkt;
endmodule

// File: tb/tb_local_controller_prefetch_full.sv
// Four-node ring bench: a behavioural ring model fills a scoreboard of expected (cycle, value) events per output channel.
module tb_local_controller_prefetch_full;
  localparam int N = 4, MW = 32, VW = 8, AW = 8, PW = 40, NCH = 20;

  typedef struct packed { int cyc; logic [PW-1:0] val; } exp_t;
  exp_t sbq[NCH][$];

  logic CLK = 1'b0;
  logic reset;
  logic [MW-1:0] D, DM, BWEBM;
  logic WEBM, scen;
  logic [N-1:0] write_flag, wbn, gvalid, bn, pvalid, bp;
  logic [N-1:0][AW-1:0] gdelay, pstart, pstopi, pstop;
  logic [N-1:0][VW-1:0] gdest, dadr, pdesti, pdest;
  logic [N-1:0][PW-1:0] pkt, ppkt;

  for (genvar i = 0; i < N; i++) begin : g_node
    localparam int P = (i + N - 1) % N;
    localparam int S = (i + 1) % N;
    local_controller_prefetch_full dut (
      .CLK(CLK), .reset(reset), .D(D),
      .write_flag(write_flag[i]), .input_write_boundary(wbn[P]), .write_boundary_next(wbn[i]),
      .from_glob_controller_valid(gvalid[i]), .from_glob_controller_delay(gdelay[i]),
      .from_glob_dest_addr(gdest[i]), .input_boundary_flag(bn[P]), .prev_dest_address(dadr[P]),
      .boundary_next(bn[i]), .dest_address(dadr[i]), .packet_out(pkt[i]),
      .from_glob_prefetch_valid(pvalid[i]), .from_glob_prefetch_start(pstart[i]),
      .from_glob_prefetch_stop(pstopi[i]), .from_glob_prefetch_dest(pdesti[i]),
      .input_prefetch_boundary_flag(bp[S]), .prefetch_next_stop_address(pstop[S]),
      .prefetch_next_dest_addr(pdest[S]), .prefetch_boundary_prev(bp[i]),
      .prefetch_stop_address(pstop[i]), .prefetch_dest_addr(pdest[i]),
      .prefetch_packet_out(ppkt[i]), .scenario_update(scen),
      .WEBM(WEBM), .DM(DM), .BWEBM(BWEBM));
  end

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int seen[NCH];
  logic [MW-1:0] tbl[1024];   // ring-global sample g lives at node g/256, address g%256
  logic wr_req = 1'b0, wr_on = 1'b0, wr_push = 1'b1;
  int wn = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push(input int ch, input int c, input logic [PW-1:0] v);
    exp_t e;
    e.cyc = c; e.val = v;
    sbq[ch].push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // read walks the ring-global sample index upward from the start point
  task automatic gen_read(input int n, input int d, input int x, input int n0, input int last);
    int g;
    for (int j = 0; n0 + j <= last; j++) begin
      g = (n * 256 + d + j) % 1024;
      push(g / 256, n0 + j, {x[VW-1:0], tbl[g]});
      if (g % 256 == 255) push(8 + g / 256, n0 + j, PW'(1));
    end
  endtask

  // prefetch descends, moving to the previous node after address 0, until the stop address
  task automatic gen_pf(input int n, input int s, input int t, input int x, input int n0,
                        input int last, output int fin);
    int m, a, c;
    m = n; a = s; c = n0;
    while (c <= last) begin
      push(4 + m, c, {x[VW-1:0], tbl[m * 256 + a]});
      if (a == t) break;
      if (a == 0) begin
        push(12 + m, c, PW'(1));
        m = (m + N - 1) % N;
        a = 255;
      end else a--;
      c++;
    end
    fin = c;
  endtask

  task automatic abort_at(input int a);
    wait_cyc(a);
    scen = 1'b1;
    tick();
    scen = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("abort pkt%0d", i), pkt[i], '0);
      chk($sformatf("abort ppkt%0d", i), ppkt[i], '0);
      chk($sformatf("abort dests%0d", i), PW'({dadr[i], pstop[i], pdest[i], bn[i], bp[i]}), '0);
    end
  endtask

  function automatic logic [PW-1:0] actual(input int ch);
    case (ch / 4)
      0: return pkt[ch % 4];
      1: return ppkt[ch % 4];
      2: return PW'(bn[ch % 4]);
      3: return PW'(bp[ch % 4]);
      default: return PW'(wbn[ch % 4]);
    endcase
  endfunction

  // write driver: ring-global sample index modulo 1024, so memory is identical every lap
  initial begin
    write_flag = '0;
    D = '0;
    forever begin
      @(negedge CLK);
      write_flag = '0;
      if (wr_req) begin
        wr_req = 1'b0; write_flag[0] = 1'b1; wn = 0; wr_on = 1'b1;
      end
      if (wr_on) begin
        D = tbl[wn % 1024];
        if (wn % 256 == 255 && wr_push) push(16 + (wn / 256) % 4, cyc + 1, PW'(1));
        wn++;
      end else D = $urandom;
    end
  end

  // monitor
  initial begin
    exp_t e;
    logic [PW-1:0] act;
    forever begin
      @(negedge CLK);
      for (int ch = 0; ch < NCH; ch++) begin
        act = actual(ch);
        if (act != '0) seen[ch]++;
        if (sbq[ch].size() > 0 && sbq[ch][0].cyc == cyc) begin
          e = sbq[ch].pop_front();
          chk($sformatf("ch%0d", ch), act, e.val);
        end else if (act != '0) begin
          n_chk++;
          $display("FAIL ch%0d unexpected: got %h, expected 0 (cycle %0d)", ch, act, cyc);
        end
      end
    end
  end

  initial begin
    int n0, a, fin, fin2, b0, b1, b2, b3, rn, rd, rx, pn, ps, pt, px, left;
    logic [31:0] r;
    for (int i = 0; i < 1024; i++) begin
      r = $urandom;
      tbl[i] = {r[31:16], 16'(i)};
    end
    for (int i = 0; i < NCH; i++) seen[i] = 0;
    reset = 1'b1; scen = 1'b0; WEBM = 1'b1; DM = $urandom; BWEBM = $urandom;
    gvalid = '0; gdelay = '0; gdest = '0; pvalid = '0; pstart = '0; pstopi = '0; pdesti = '0;
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset pkt%0d", i), pkt[i], '0);
      chk($sformatf("reset ppkt%0d", i), ppkt[i], '0);
      chk($sformatf("reset ctl%0d", i),
          PW'({dadr[i], pstop[i], pdest[i], bn[i], bp[i], wbn[i]}), '0);
    end
    reset = 1'b0;
    tick();
    wr_req = 1'b1;
    wait_cyc(cyc + 1030);

    // delayed read from node2, continues into node3 and node0
    b2 = seen[2];
    n0 = cyc + 1; a = n0 + 231 + 256 + 40;
    gen_read(2, 'h19, 'h08, n0, a);
    gvalid[2] = 1'b1; gdelay[2] = 8'h19; gdest[2] = 8'h08;
    tick(); gvalid[2] = 1'b0;
    wait_cyc(n0 + 300);
    chk("dest3 handoff", PW'(dadr[3]), PW'(8'h08));
    chk("dest2 hold", PW'(dadr[2]), PW'(8'h08));
    abort_at(a);
    chk("node2 read count", PW'(seen[2] - b2), PW'(231));

    // prefetch from node3 handing off to node2
    b3 = seen[7]; b2 = seen[6];
    n0 = cyc + 1;
    gen_pf(3, 'h30, 'hE0, 'h6F, n0, n0 + 2000, fin);
    pvalid[3] = 1'b1; pstart[3] = 8'h30; pstopi[3] = 8'hE0; pdesti[3] = 8'h6F;
    tick(); pvalid[3] = 1'b0;
    wait_cyc(fin + 3);
    chk("pf node3 count", PW'(seen[7] - b3), PW'(49));
    chk("pf node2 count", PW'(seen[6] - b2), PW'(32));
    chk("pf latched 3", PW'({pstop[3], pdest[3]}), PW'(16'hE06F));
    chk("pf latched 2", PW'({pstop[2], pdest[2]}), PW'(16'hE06F));

    // local prefetch, no hand-off
    b1 = seen[5]; b0 = seen[13];
    n0 = cyc + 1;
    gen_pf(1, 'h10, 'h08, 'h35, n0, n0 + 2000, fin);
    pvalid[1] = 1'b1; pstart[1] = 8'h10; pstopi[1] = 8'h08; pdesti[1] = 8'h35;
    tick(); pvalid[1] = 1'b0;
    wait_cyc(fin + 3);
    chk("local pf count", PW'(seen[5] - b1), PW'(9));
    chk("local pf no bprev", PW'(seen[13] - b0), '0);

    // abort mid read and mid prefetch
    n0 = cyc + 1; a = n0 + 20;
    gen_read(1, 'h40, 'h5A, n0, a);
    gen_pf(0, 'hC0, 'h05, 'h44, n0, a, fin);
    gvalid[1] = 1'b1; gdelay[1] = 8'h40; gdest[1] = 8'h5A;
    pvalid[0] = 1'b1; pstart[0] = 8'hC0; pstopi[0] = 8'h05; pdesti[0] = 8'h44;
    tick(); gvalid[1] = 1'b0; pvalid[0] = 1'b0;
    abort_at(a);

    // restart of an active read
    n0 = cyc + 1; a = n0 + 105;
    gen_read(1, 'h10, 'h21, n0, n0 + 4);
    gen_read(1, 'h80, 'h22, n0 + 5, a);
    gvalid[1] = 1'b1; gdelay[1] = 8'h10; gdest[1] = 8'h21;
    tick(); gvalid[1] = 1'b0;
    wait_cyc(n0 + 4);
    gvalid[1] = 1'b1; gdelay[1] = 8'h80; gdest[1] = 8'h22;
    tick(); gvalid[1] = 1'b0;
    abort_at(a);

    // randomized concurrent read + prefetch, aborted at a random point
    b0 = seen[16] + seen[17] + seen[18] + seen[19];
    for (int it = 0; it < 6; it++) begin
      rn = $urandom_range(0, 3); rd = $urandom_range(0, 255); rx = $urandom_range(1, 255);
      pn = $urandom_range(0, 3); ps = $urandom_range(0, 255); pt = $urandom_range(0, 255);
      px = $urandom_range(1, 255);
      n0 = cyc + 1; a = n0 + $urandom_range(1, 600);
      gen_read(rn, rd, rx, n0, a);
      gen_pf(pn, ps, pt, px, n0, a, fin);
      gvalid[rn] = 1'b1; gdelay[rn] = AW'(rd); gdest[rn] = VW'(rx);
      pvalid[pn] = 1'b1; pstart[pn] = AW'(ps); pstopi[pn] = AW'(pt); pdesti[pn] = VW'(px);
      tick(); gvalid = '0; pvalid = '0;
      abort_at(a);
      tick();
    end
    chk("write ring still running", PW'(seen[16] + seen[17] + seen[18] + seen[19] > b0), PW'(1));

    // asynchronous reset in the middle of streams
    n0 = cyc + 1; a = n0 + 50;
    gen_read(0, 0, 'h77, n0, a - 1);
    gen_pf(3, 'hFF, 'h00, 'h12, n0, a - 1, fin2);
    gvalid[0] = 1'b1; gdelay[0] = 8'h00; gdest[0] = 8'h77;
    pvalid[3] = 1'b1; pstart[3] = 8'hFF; pstopi[3] = 8'h00; pdesti[3] = 8'h12;
    tick(); gvalid = '0; pvalid = '0;
    wait_cyc(a - 1);
    wr_push = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("async rst pkt%0d", i), pkt[i], '0);
      chk($sformatf("async rst ppkt%0d", i), ppkt[i], '0);
      chk($sformatf("async rst ctl%0d", i),
          PW'({dadr[i], pstop[i], pdest[i], bn[i], bp[i], wbn[i]}), '0);
    end
    repeat (3) tick();

    left = 0;
    for (int ch = 0; ch < NCH; ch++) left += sbq[ch].size();
    chk("scoreboard drained", PW'(left), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
